// File: rtl/wptr_full.sv
// wptr_full: write-domain binary/Gray pointer, memory write enable and registered full flag; 1-edge latency.
// Writes while full are dropped and flagged on o_woverflow; WPTR_FULL_LEVEL_EN adds o_wlevel/o_walmost_full.
module wptr_full #(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                i_wclk,
  input  logic                i_wrst,
  input  logic                i_winc,
  input  logic [ADDRSIZE:0]   i_rptr_sync,
  output logic [ADDRSIZE-1:0] o_waddr,
  output logic                o_wen,
  output logic [ADDRSIZE:0]   o_wptr,
  output logic                o_wfull,
  output logic                o_woverflow
`ifdef WPTR_FULL_LEVEL_EN
  ,
  output logic [ADDRSIZE:0]   o_wlevel,
  output logic                o_walmost_full
`endif
);

  if (ADDRSIZE < 2) begin : g_bad_addrsize
    $error("wptr_full: ADDRSIZE must be >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > (1 << ADDRSIZE)) begin : g_bad_thresh
    $error("wptr_full: AFULL_THRESH out of range");
  end

  logic [ADDRSIZE:0] r_wbin;
  logic              w_push;
  logic [ADDRSIZE:0] w_wbin_next;
  logic [ADDRSIZE:0] w_wgray_next;
  logic [ADDRSIZE:0] w_full_cmp;
  logic              w_full_next;

  assign w_push       = i_winc & ~o_wfull;
  assign w_wbin_next  = r_wbin + {{ADDRSIZE{1'b0}}, w_push};
  assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;
  // Full when the write pointer is exactly one lap ahead of the read pointer.
  assign w_full_cmp   = {~i_rptr_sync[ADDRSIZE:ADDRSIZE-1], i_rptr_sync[ADDRSIZE-2:0]};
  assign w_full_next  = (w_wgray_next == w_full_cmp);

  assign o_waddr = r_wbin[ADDRSIZE-1:0];
  assign o_wen   = w_push & ~i_wrst;

  always_ff @(posedge i_wclk) begin
    if (i_wrst) begin
      r_wbin      <= '0;
      o_wptr      <= '0;
      o_wfull     <= 1'b0;
      o_woverflow <= 1'b0;
    end else begin
      r_wbin      <= w_wbin_next;
      o_wptr      <= w_wgray_next;
      o_wfull     <= w_full_next;
      o_woverflow <= i_winc & o_wfull;
    end
  end

`ifdef WPTR_FULL_LEVEL_EN
  localparam logic [ADDRSIZE:0] LP_AFULL = (ADDRSIZE+1)'(AFULL_THRESH);

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  logic [ADDRSIZE:0] w_rbin;
  logic [ADDRSIZE:0] w_level;

  assign w_rbin  = gray2bin(i_rptr_sync);
  // Synchronizer lag makes this an overestimate, which errs toward backpressure.
  assign w_level = w_wbin_next - w_rbin;

  always_ff @(posedge i_wclk) begin
    if (i_wrst) begin
      o_wlevel       <= '0;
      o_walmost_full <= 1'b0;
    end else begin
      o_wlevel       <= w_level;
      o_walmost_full <= (w_level >= LP_AFULL);
    end
  end
`endif

endmodule

// File: tb/tb_wptr_full.sv
// Bench for wptr_full (ADDRSIZE=4): vector table driven at negedge, post-edge expectations checked via a scoreboard queue.
module tb_wptr_full;

  logic       i_wclk;
  logic       i_wrst;
  logic       i_winc;
  logic [4:0] i_rptr_sync;
  logic [3:0] o_waddr;
  logic       o_wen;
  logic [4:0] o_wptr;
  logic       o_wfull;
  logic       o_woverflow;
`ifdef WPTR_FULL_LEVEL_EN
  logic [4:0] o_wlevel;
  logic       o_walmost_full;
`endif

  wptr_full #(.ADDRSIZE(4), .AFULL_THRESH(12)) dut (
    .i_wclk         (i_wclk),
    .i_wrst         (i_wrst),
    .i_winc         (i_winc),
    .i_rptr_sync    (i_rptr_sync),
    .o_waddr        (o_waddr),
    .o_wen          (o_wen),
    .o_wptr         (o_wptr),
    .o_wfull        (o_wfull),
    .o_woverflow    (o_woverflow)
`ifdef WPTR_FULL_LEVEL_EN
    ,
    .o_wlevel       (o_wlevel),
    .o_walmost_full (o_walmost_full)
`endif
  );

  initial i_wclk = 1'b0;
  always #5 i_wclk = ~i_wclk;

  typedef struct {
    logic       rst;
    logic       winc;
    logic [4:0] rptr;
    logic       e_wen;
    logic [3:0] e_waddr;
    logic [4:0] e_wptr;
    logic       e_full;
    logic       e_ovf;
  } vec_t;

  typedef struct {
    int         idx;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       full;
    logic       ovf;
  } exp_t;

  vec_t tbl[64];
  int   n_vec = 0;
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, req);
    end
  endtask

  function automatic void add(input logic rst, input logic winc, input logic [4:0] rptr, input logic wen,
                              input logic [3:0] waddr, input logic [4:0] wptr, input logic full, input logic ovf);
    tbl[n_vec] = '{rst, winc, rptr, wen, waddr, wptr, full, ovf};
    n_vec++;
  endfunction

  // Scoreboard: one expectation per driven row, checked #1 after the edge that consumed it.
  always @(posedge i_wclk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("waddr", e.idx, 32'(o_waddr), 32'(e.waddr));
      chk("wptr",  e.idx, 32'(o_wptr),  32'(e.wptr));
      chk("wfull", e.idx, 32'(o_wfull), 32'(e.full));
      chk("wovf",  e.idx, 32'(o_woverflow), 32'(e.ovf));
    end
  end

  initial begin
    logic [4:0] g[0:31];
    for (int k = 0; k < 32; k++) g[k] = 5'(k ^ (k >> 1));

    i_wrst = 1'b1;
    i_winc = 1'b0;
    i_rptr_sync = 5'd0;

    // Reset held 3 cycles with a write request pending.
    for (int k = 0; k < 3; k++) add(1, 1, 5'd0, 0, 4'd0, 5'd0, 0, 0);
    // Fill 16 entries against an empty reader.
    for (int k = 1; k <= 16; k++) add(0, 1, 5'd0, 1, 4'(k), g[k], (k == 16), 0);
    // Rejected write, then idle: overflow pulses once.
    add(0, 1, 5'd0, 0, 4'd0, 5'b11000, 1, 1);
    add(0, 0, 5'd0, 0, 4'd0, 5'b11000, 1, 0);
    // Reader frees one slot; one write refills it on the same edge.
    add(0, 0, 5'b00001, 0, 4'd0, 5'b11000, 0, 0);
    add(0, 1, 5'b00001, 1, 4'd1, 5'b11001, 1, 0);
    add(0, 1, 5'b00001, 0, 4'd1, 5'b11001, 1, 1);
    // Wrap: reader at 20, writer runs 17 -> 31 -> 4 and fills.
    add(0, 0, 5'b11110, 0, 4'd1, 5'b11001, 0, 0);
    for (int k = 18; k <= 36; k++) add(0, 1, 5'b11110, 1, 4'(k), g[k % 32], (k == 36), 0);
    add(0, 1, 5'b11110, 0, 4'd4, 5'b00110, 1, 1);
    // Mid-operation reset overrides a write, then restart.
    add(1, 1, 5'b11110, 0, 4'd0, 5'd0, 0, 0);
    add(0, 0, 5'd0, 0, 4'd0, 5'd0, 0, 0);
    add(0, 1, 5'd0, 1, 4'd1, 5'd1, 0, 0);

    for (int i = 0; i < n_vec; i++) begin
      exp_t e;
      @(negedge i_wclk);
      i_wrst      = tbl[i].rst;
      i_winc      = tbl[i].winc;
      i_rptr_sync = tbl[i].rptr;
      #1;
      chk("wen", i, 32'(o_wen), 32'(tbl[i].e_wen));
      e = '{i, tbl[i].e_waddr, tbl[i].e_wptr, tbl[i].e_full, tbl[i].e_ovf};
      exp_q.push_back(e);
    end
    repeat (2) @(negedge i_wclk);
    chk("sb_drained", 0, 32'(exp_q.size()), 32'd0);

`ifdef WPTR_FULL_LEVEL_EN
    @(negedge i_wclk);
    i_wrst = 1'b1;
    i_winc = 1'b0;
    i_rptr_sync = 5'd0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge i_wclk);
      i_wrst = 1'b0;
      i_winc = 1'b1;
      @(posedge i_wclk);
      #1;
      chk("wlevel", k, 32'(o_wlevel), 32'(k));
      chk("walmost_full", k, 32'(o_walmost_full), 32'(k >= 12));
    end
    @(negedge i_wclk);
    i_winc = 1'b0;
    i_rptr_sync = 5'b00010;
    @(posedge i_wclk);
    #1;
    chk("wlevel_drain", 0, 32'(o_wlevel), 32'd9);
    chk("walmost_full_drain", 0, 32'(o_walmost_full), 32'd0);
`endif

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    if (!done) begin
      $display("FAIL timeout: simulation did not complete, expected completion before 20000");
      $fatal(1, "timeout");
    end
  end

endmodule
